// File: rtl/sram16_target.sv
// Pipeconnect target serving 32-bit word requests from an asynchronous 16-bit SRAM.
// Each word is two big-endian halfword phases of WAIT+1 cycles; empty write halves are skipped.
module sram16_target #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       req_a,
  input  logic              req_r,
  input  logic              req_w,
  input  logic [31:0]       req_wd,
  input  logic [3:0]        req_wbe,
  output logic [31:0]       res_rd,
  output logic              res_hold,
  output logic [ADDR_W-1:0] sram_a,
  output logic [15:0]       sram_d,
  output logic              sram_d_oe,
  input  logic [15:0]       sram_d_in,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH0  = 2'd1;
  localparam logic [1:0] PH1  = 2'd2;

  localparam logic [3:0] WaitCnt = 4'(WAIT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-2:0] addr_q;
  logic              wr_q;
  logic [31:0]       wd_q;
  logic [3:0]        wbe_q;
  logic [31:0]       rd_q;

  logic       accept;
  logic       last;
  logic       in_ph;
  logic       is_ph1;
  logic [1:0] be;
  logic       unused_a;

  assign unused_a = ^{req_a[31:ADDR_W+1], req_a[1:0]};

  assign accept = (state_q == IDLE) && (req_r || req_w);
  assign last   = (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // A write with no enabled bytes in a half skips that phase entirely.
          if (!req_w || (req_wbe[3:2] != 2'b00)) begin
            state_d = PH0;
            cnt_d   = WaitCnt;
          end else if (req_wbe[1:0] != 2'b00) begin
            state_d = PH1;
            cnt_d   = WaitCnt;
          end
        end
      end
      PH0: begin
        if (last) begin
          if (!wr_q || (wbe_q[1:0] != 2'b00)) begin
            state_d = PH1;
            cnt_d   = WaitCnt;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      PH1: begin
        if (last) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wd_q    <= 32'd0;
      wbe_q   <= 4'd0;
      rd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= req_a[ADDR_W:2];
        wr_q   <= req_w;
        wd_q   <= req_wd;
        wbe_q  <= req_wbe;
      end
      if (!wr_q && last && (state_q == PH0)) rd_q[31:16] <= sram_d_in;
      if (!wr_q && last && (state_q == PH1)) rd_q[15:0]  <= sram_d_in;
    end
  end

  // Strobes decode from registered state only, so reset releases them immediately.
  assign in_ph  = (state_q == PH0) || (state_q == PH1);
  assign is_ph1 = (state_q == PH1);
  assign be     = is_ph1 ? wbe_q[1:0] : wbe_q[3:2];

  assign res_rd    = rd_q;
  assign res_hold  = in_ph;
  assign sram_a    = {addr_q, is_ph1};
  assign sram_d    = is_ph1 ? wd_q[15:0] : wd_q[31:16];
  assign sram_d_oe = in_ph && wr_q;
  assign sram_cs_n = !in_ph;
  assign sram_oe_n = !(in_ph && !wr_q);
  // we_n rises one cycle before the phase ends so data and address hold past it.
  assign sram_we_n = !(in_ph && wr_q && !last);
  assign sram_ub_n = !(in_ph && (!wr_q || be[1]));
  assign sram_lb_n = !(in_ph && (!wr_q || be[0]));

endmodule

// File: tb/tb_sram16_target.sv
// Scoreboard bench for sram16_target: behavioural async SRAM, driver pushes expected
// completions, a negedge monitor pops them when res_hold falls.
module tb_sram16_target;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] req_a = 32'd0;
  logic        req_r = 1'b0;
  logic        req_w = 1'b0;
  logic [31:0] req_wd = 32'd0;
  logic [3:0]  req_wbe = 4'd0;
  logic [31:0] res_rd;
  logic        res_hold;
  logic [17:0] sram_a;
  logic [15:0] sram_d;
  logic        sram_d_oe;
  logic [15:0] sram_d_in;
  logic        sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  sram16_target #(.ADDR_W(18), .WAIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_r     (req_r),
    .req_w     (req_w),
    .req_wd    (req_wd),
    .req_wbe   (req_wbe),
    .res_rd    (res_rd),
    .res_hold  (res_hold),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_d_oe (sram_d_oe),
    .sram_d_in (sram_d_in),
    .sram_cs_n (sram_cs_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM model; writes land on clock edges while we_n is low.
  logic [15:0] mem [0:(1<<18)-1];
  logic        pre_en = 1'b0;
  logic [17:0] pre_addr = 18'd0;
  logic [15:0] pre_data = 16'd0;

  assign sram_d_in = (!sram_cs_n && !sram_oe_n) ? mem[sram_a] : 16'h0000;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (!sram_cs_n && !sram_we_n && sram_d_oe) begin
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_d[15:8];
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_d[7:0];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe statistics sampled mid-cycle.
  int   we_low = 0;
  int   we_pulses = 0;
  int   cs_low = 0;
  logic we_prev = 1'b1;
  initial forever begin
    @(negedge clk);
    if (!sram_we_n) we_low++;
    if (!sram_we_n && we_prev) we_pulses++;
    if (!sram_cs_n) cs_low++;
    we_prev = sram_we_n;
  end

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
    logic [31:0] hold;
  } exp_t;

  exp_t sb[$];
  int   abort_req = 0;
  int   abort_done = 0;
  int   done_cyc = 0;
  int   done_cyc_prev = 0;

  initial begin : monitor
    int   hlen;
    logic hold_prev;
    exp_t e;
    hlen = 0;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (res_hold) begin
        hlen++;
      end else begin
        if (hold_prev) begin
          if (abort_done != abort_req) begin
            abort_done++;
          end else if (sb.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("hold_len", 32'(hlen), e.hold);
            if (e.rd) begin
              check("rd_data", res_rd, e.data);
              done_cyc_prev = done_cyc;
              done_cyc = cyc;
            end
          end
        end
        hlen = 0;
      end
      hold_prev = res_hold;
    end
  end

  // Presents a request, keeps it stable while held, returns in the cycle after completion.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_data, input int exp_hold);
    int n;
    req_r = r;
    req_w = w;
    req_a = a;
    req_wd = wd;
    req_wbe = be;
    if (exp_hold > 0) sb.push_back('{rd: r & ~w, data: exp_data, hold: 32'(exp_hold)});
    @(posedge clk);
    #1;
    n = 0;
    while (res_hold && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (res_hold) check("hold_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    req_r = 1'b0;
    req_w = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : stim
    int base_p, base_l;
    // Preload halfwords {W=4,0} and {W=4,1} during reset.
    pre_en = 1'b1;
    pre_addr = 18'd8;
    pre_data = 16'h1234;
    @(posedge clk);
    #1;
    pre_addr = 18'd9;
    pre_data = 16'h5678;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
    @(negedge clk);
    check("rst_res_rd", res_rd, 32'd0);
    check("rst_hold", 32'(res_hold), 32'd0);
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_sram_d", 32'(sram_d), 32'd0);
    check("rst_d_oe", 32'(sram_d_oe), 32'd0);
    check("rst_strobes", 32'({sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Preloaded read: hold 6 cycles, data in cycle 7.
    do_req(1'b1, 1'b0, 32'h4000_0010, 32'd0, 4'h0, 32'h1234_5678, 6);

    // Full write then readback; two 2-cycle we_n pulses.
    base_p = we_pulses;
    base_l = we_low;
    do_req(1'b0, 1'b1, 32'h4000_0020, 32'hCAFE_BABE, 4'hF, 32'd0, 6);
    do_req(1'b1, 1'b0, 32'h4000_0020, 32'd0, 4'h0, 32'hCAFE_BABE, 6);
    check("we_pulses", 32'(we_pulses - base_p), 32'd2);
    check("we_low_cycles", 32'(we_low - base_l), 32'd4);

    // Low-half-only write.
    do_req(1'b0, 1'b1, 32'h0000_0030, 32'h1111_2222, 4'hF, 32'd0, 6);
    do_req(1'b0, 1'b1, 32'h0000_0030, 32'hAAAA_5555, 4'h3, 32'd0, 3);
    do_req(1'b1, 1'b0, 32'h0000_0030, 32'd0, 4'h0, 32'h1111_5555, 6);

    // Empty write: no SRAM cycle, no hold.
    base_l = cs_low;
    do_req(1'b0, 1'b1, 32'h0000_0030, 32'h9999_9999, 4'h0, 32'd0, 0);
    check("wbe0_hold", 32'(res_hold), 32'd0);
    idle();
    idle();
    check("wbe0_cs_low", 32'(cs_low - base_l), 32'd0);

    // Read+write together is a write; high half only.
    do_req(1'b1, 1'b1, 32'h0000_0030, 32'hDEAD_BEEF, 4'hC, 32'd0, 3);
    do_req(1'b1, 1'b0, 32'h0000_0030, 32'd0, 4'h0, 32'hDEAD_5555, 6);
    idle();

    // Back-to-back reads with no bubble.
    do_req(1'b1, 1'b0, 32'h4000_0010, 32'd0, 4'h0, 32'h1234_5678, 6);
    do_req(1'b1, 1'b0, 32'h4000_0020, 32'd0, 4'h0, 32'hCAFE_BABE, 6);
    idle();
    idle();
    check("b2b_spacing", 32'(done_cyc - done_cyc_prev), 32'd7);

    // Reset during PH0 of a write.
    req_r = 1'b0;
    req_w = 1'b1;
    req_a = 32'h0000_0060;
    req_wd = 32'hFFFF_FFFF;
    req_wbe = 4'hF;
    @(posedge clk);
    #1;
    check("ph0_we_low", 32'(sram_we_n), 32'd0);
    abort_req++;
    #5;
    rst = 1'b0;
    #1;
    check("arst_strobes", 32'({sram_cs_n, sram_we_n}), 32'h3);
    check("arst_d_oe", 32'(sram_d_oe), 32'd0);
    check("arst_hold", 32'(res_hold), 32'd0);
    req_w = 1'b0;
    req_wbe = 4'h0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b1, 1'b0, 32'h4000_0010, 32'd0, 4'h0, 32'h1234_5678, 6);
    idle();
    idle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram16_target.md
# sram16_target

Pipeconnect target (responder) that serves 32-bit word requests from the bus controller's SRAM target port against an external asynchronous 16-bit SRAM. Each word access is split into two halfword phases with a programmable wait-state count. The bus side is stalled with `res_hold` while an access is in flight. Byte-enable-masked writes skip unused halfword phases.

## Interface
- `ADDR_W`, 18: SRAM halfword address width (2^18 halfwords = 512 KiB).
- `WAIT`, 2: extra cycles per halfword phase; legal range 1..15. Phase length is `WAIT`+1 cycles.

- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-low.
- `req_a`  in  32  byte address; bits [ADDR_W:2] are used, all others ignored.
- `req_r`  in  1  read request.
- `req_w`  in  1  write request.
- `req_wd`  in  32  write data.
- `req_wbe`  in  4  write byte enables; bit 3 selects byte [31:24].
- `res_rd`  out  32  read data.
- `res_hold`  out  1  stall; the master keeps its request stable while this is high.
- `sram_a`  out  ADDR_W  halfword address.
- `sram_d`  out  16  write data.
- `sram_d_oe`  out  1  tri-state enable for `sram_d`.
- `sram_d_in`  in  16  read data from the pad.
- `sram_cs_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  active-low SRAM strobes.

## Operation
- FSM states: IDLE, PH0, PH1.
- `res_hold` = (state != IDLE). It is decoded from registered state and does not depend combinationally on `req_*`.
- Acceptance: a request is accepted on a rising edge where state is IDLE and `req_r|req_w` is high.
  - Fields are latched into internal registers on that edge.
  - If `req_r` and `req_w` are both high, the request is treated as a write.
- Word address is W = `req_a[ADDR_W:2]`. The layout is big-endian.
  - PH0 drives halfword {W,0}, which carries bits [31:16]. `ub_n` maps to `wbe[3]` and `lb_n` maps to `wbe[2]`.
  - PH1 drives halfword {W,1}, which carries bits [15:0]. `ub_n` maps to `wbe[1]` and `lb_n` maps to `wbe[0]`.
- Read: IDLE → PH0 → PH1 → IDLE.
  - `oe_n`, `cs_n`, `ub_n`, `lb_n` are low for the whole of both phases.
  - `sram_d_in` is sampled on the last edge of each phase, into `res_rd[31:16]` and then `res_rd[15:0]`.
- Write: a phase runs only if its byte enables are non-zero.
  - Transitions: IDLE → PH0 if `wbe[3:2]`≠0, otherwise PH1. PH0 → PH1 if `wbe[1:0]`≠0, otherwise IDLE.
  - A write with `wbe`=0 is accepted, performs no SRAM cycle, and never raises hold.
  - During a write phase: `cs_n` low, `sram_d_oe` high, `sram_d` and `sram_a` stable for the whole phase. `we_n` is low for the first `WAIT` cycles and high in the last cycle (data and address hold).
- Wait counter: 4 bits, loaded with `WAIT` on phase entry, decremented each cycle. The phase ends on the edge where the counter is 0.
- `res_rd` keeps its value until the next read overwrites it. Writes never change it.
- Outside PH0/PH1, all strobes are high and `sram_d_oe` is low.

## Timing
- Reset values: `res_rd`=0, `res_hold`=0, `sram_a`=0, `sram_d`=0, `sram_d_oe`=0, all `*_n`=1, FSM=IDLE, counter=0.
- Reset asserted mid-access:
  - Strobes go high and `sram_d_oe` goes low immediately (asynchronously); the partial access is abandoned.
  - `res_hold` is 0 after reset.
- Read, request presented in cycle 0:
  - `res_hold` high in cycles 1..2(`WAIT`+1).
  - `res_rd` valid in cycle 2`WAIT`+3 with hold low. For `WAIT`=2: hold in cycles 1–6, data in cycle 7.
- Write with full `wbe`: hold for 2(`WAIT`+1) cycles. Single-half write: `WAIT`+1 cycles.
- Back-to-back: a new request presented in the cycle the read data is valid is accepted on that edge, so there are no idle bubbles.
- Requests presented while hold is high are not sampled and must stay stable.

## Test plan
- Reset during PH0 of a write (`WAIT`=2) → `we_n`, `cs_n` = 1 and `sram_d_oe`=0 before the next edge; `res_hold`=0; the next read completes normally.
- SRAM model preloaded with {W,0}=0x1234 and {W,1}=0x5678; read `req_a`=0x40000010 → hold for cycles 1–6, `res_rd`=0x12345678 in cycle 7.
- Write 0xCAFEBABE, `wbe`=0xF to 0x40000020, then read it back → 0xCAFEBABE. `we_n` pulses exactly twice, each pulse 2 cycles long.
- Write `wbe`=0x3, data 0xAAAA5555 over a location holding 0x11112222 → only PH1 runs, hold lasts 3 cycles, readback is 0x11115555.
- `wbe`=0 write → hold never rises, `cs_n` stays 1; `req_r`=`req_w`=1 with `wbe`=0xC and data 0xDEADxxxx over 0x11115555 → processed as a PH0-only write, readback is 0xDEAD5555.
- Two reads issued back-to-back, the second presented in the data cycle of the first → both return correct data, second data valid 7 cycles after the first.
